// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: sequences fetch addresses toward the I-cache and queues
// fetched instructions (with PC and access-fault flag) for the decoder.
module ifetch_buffer #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          DEPTH       = 8,
    parameter logic [63:0] RESET_PC    = 64'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_en,
    input  logic [63:0]               redirect_pc,
    input  logic                      redirect_fence_i,
    output logic [63:0]               ibus_addr,
    output logic                      ibus_en,
    input  logic [32*FETCH_WIDTH-1:0] ibus_rdata,
    input  logic                      ibus_valid,
    output logic                      ibus_ready,
    output logic                      ibus_fence_i,
    input  logic                      ibus_acc_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_inst,
    output logic [63:0]               out_pc,
    output logic                      out_acc_err
);

    localparam int          PTR_W      = $clog2(DEPTH);
    localparam int          CNT_W      = $clog2(DEPTH + 1);
    localparam logic [63:0] BEAT_BYTES = 64'(4 * FETCH_WIDTH);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_FENCE   = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [63:0]        fpc_r;
    logic [63:0]        hold_addr_r;
    logic [63:0]        fetch_addr_s;
    logic               fence_pend_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   start_slot_s;
    logic [CNT_W-1:0]   need_s;
    logic [CNT_W-1:0]   free_s;
    logic [31:0]        mem_inst_r [DEPTH];
    logic [63:0]        mem_pc_r [DEPTH];
    logic [DEPTH-1:0]   mem_err_r;
    logic               en_raw_s;
    logic               ready_raw_s;
    logic               fence_raw_s;
    logic               hs_s;
    logic               push_s;
    logic               pop_s;
    logic               valid_s;

    // Bus-side decode: beat alignment, start slot, free space and per-state strobes
    always_comb begin
        fetch_addr_s = fpc_r & ~(BEAT_BYTES - 64'd1);
        start_slot_s = CNT_W'(fpc_r[63:2] & 62'(FETCH_WIDTH - 1));
        free_s       = CNT_W'(DEPTH) - count_r;
        need_s       = CNT_W'(FETCH_WIDTH) - start_slot_s;
        en_raw_s     = 1'b0;
        ready_raw_s  = 1'b0;
        fence_raw_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                en_raw_s    = 1'b1;
                ready_raw_s = (free_s >= need_s);
            end
            ST_DISCARD: begin
                en_raw_s    = 1'b1;
                ready_raw_s = 1'b1;
            end
            ST_FENCE: fence_raw_s = 1'b1;
            default:  en_raw_s    = 1'b0;
        endcase
    end

    // Strobes are held low while reset is asserted so no beat can start mid-reset
    assign ibus_en      = en_raw_s & ~rst;
    assign ibus_ready   = ready_raw_s & ~rst;
    assign ibus_fence_i = fence_raw_s & ~rst;
    assign ibus_addr    = (state_r == ST_DISCARD) ? hold_addr_r : fetch_addr_s;

    assign hs_s    = ibus_en & ibus_valid & ibus_ready;
    assign push_s  = hs_s & (state_r == ST_FETCH) & ~redirect_en;
    assign valid_s = (count_r != {CNT_W{1'b0}});
    assign pop_s   = valid_s & out_ready & ~redirect_en;

    assign out_valid   = valid_s;
    assign out_inst    = valid_s ? mem_inst_r[rd_ptr_r] : 32'd0;
    assign out_pc      = valid_s ? mem_pc_r[rd_ptr_r] : 64'd0;
    assign out_acc_err = valid_s & mem_err_r[rd_ptr_r];

    // Next-state: a redirect drops any same-cycle beat, otherwise waits out a pending one
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_en) begin
            case (state_r)
                ST_FETCH: begin
                    if (hs_s) state_nxt_s = redirect_fence_i ? ST_FENCE : ST_FETCH;
                    else      state_nxt_s = ST_DISCARD;
                end
                ST_DISCARD: begin
                    if (hs_s) state_nxt_s = redirect_fence_i ? ST_FENCE : ST_FETCH;
                    else      state_nxt_s = ST_DISCARD;
                end
                default: state_nxt_s = redirect_fence_i ? ST_FENCE : ST_FETCH;
            endcase
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (hs_s && ibus_acc_err) state_nxt_s = ST_HALT;
                    else                      state_nxt_s = ST_FETCH;
                end
                ST_DISCARD: begin
                    if (hs_s) state_nxt_s = fence_pend_r ? ST_FENCE : ST_FETCH;
                    else      state_nxt_s = ST_DISCARD;
                end
                ST_FENCE: state_nxt_s = ST_FETCH;
                ST_HALT:  state_nxt_s = ST_HALT;
                default:  state_nxt_s = ST_FETCH;
            endcase
        end
    end

    // Control registers: state, fetch PC, held discard address, queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            fpc_r        <= RESET_PC;
            hold_addr_r  <= RESET_PC & ~(BEAT_BYTES - 64'd1);
            fence_pend_r <= 1'b0;
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_FETCH) begin
                hold_addr_r <= fetch_addr_s;
            end
            if (redirect_en) begin
                fpc_r        <= {redirect_pc[63:2], 2'b00};
                fence_pend_r <= redirect_fence_i;
                rd_ptr_r     <= {PTR_W{1'b0}};
                wr_ptr_r     <= {PTR_W{1'b0}};
                count_r      <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    fpc_r    <= fetch_addr_s + BEAT_BYTES;
                    wr_ptr_r <= wr_ptr_r + PTR_W'(need_s);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                count_r <= count_r + (push_s ? need_s : {CNT_W{1'b0}})
                                   - (pop_s ? CNT_W'(1) : {CNT_W{1'b0}});
            end
        end
    end

    // Queue storage: slots below the start slot belong to PCs before the fetch target
    always_ff @(posedge clk) begin
        if (push_s) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (CNT_W'(k) >= start_slot_s) begin
                    mem_inst_r[wr_ptr_r + PTR_W'(k) - PTR_W'(start_slot_s)] <= ibus_rdata[32*k +: 32];
                    mem_pc_r[wr_ptr_r + PTR_W'(k) - PTR_W'(start_slot_s)]   <= fetch_addr_s + 64'(4 * k);
                    mem_err_r[wr_ptr_r + PTR_W'(k) - PTR_W'(start_slot_s)]  <= ibus_acc_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: a cache stub answering by address, a queue-based behavioural
// model checked every cycle, and directed scenarios with literal expectations.
module tb_ifetch_buffer;

    localparam int          FW    = 2;
    localparam int          DEPTH = 8;
    localparam logic [63:0] RPC   = 64'h8000_0000;

    localparam int P_FETCH   = 0;
    localparam int P_DISCARD = 1;
    localparam int P_FENCE   = 2;
    localparam int P_HALT    = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            redirect_en;
    logic [63:0]     redirect_pc;
    logic            redirect_fence_i;
    logic [63:0]     ibus_addr;
    logic            ibus_en;
    logic [32*FW-1:0] ibus_rdata;
    logic            ibus_valid;
    logic            ibus_ready;
    logic            ibus_fence_i;
    logic            ibus_acc_err;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [63:0]     out_pc;
    logic            out_acc_err;

    always #5 clk = ~clk;

    ifetch_buffer #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .redirect_fence_i(redirect_fence_i),
        .ibus_addr(ibus_addr), .ibus_en(ibus_en), .ibus_rdata(ibus_rdata),
        .ibus_valid(ibus_valid), .ibus_ready(ibus_ready), .ibus_fence_i(ibus_fence_i),
        .ibus_acc_err(ibus_acc_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_acc_err(out_acc_err)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
    } ent_t;

    int          total = 0;
    int          bad   = 0;
    bit          check_en = 1'b0;
    bit          rec_en   = 1'b0;
    logic [63:0] popped [$];

    ent_t        m_q [$];
    int          m_phase;
    logic [63:0] m_fpc;
    logic [63:0] m_hold;
    logic        m_fence;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        logic [11:0] n;
        n = a[13:2] + 12'd1;
        return {n, 20'h00093};
    endfunction

    // Cache stub: every address returns a word derived from that address
    always_comb begin
        ibus_rdata = '0;
        for (int k = 0; k < FW; k++) begin
            ibus_rdata[32*k +: 32] = inst_of(ibus_addr + 64'(4 * k));
        end
    end

    function automatic logic [63:0] m_align();
        return m_fpc & ~(64'(4 * FW) - 64'd1);
    endfunction

    function automatic int m_slot();
        return int'((m_fpc >> 2) % 64'(FW));
    endfunction

    function automatic logic m_ready();
        if (m_phase == P_FETCH)   return (DEPTH - m_q.size()) >= (FW - m_slot());
        if (m_phase == P_DISCARD) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs currently driven
    task automatic model_step();
        logic        en;
        logic        hs;
        logic [63:0] a;
        int          s;
        ent_t        e;
        if (rst) begin
            m_q.delete();
            m_phase = P_FETCH;
            m_fpc   = RPC;
            m_hold  = RPC;
            m_fence = 1'b0;
            return;
        end
        en = (m_phase == P_FETCH) || (m_phase == P_DISCARD);
        a  = m_align();
        s  = m_slot();
        hs = en && ibus_valid && m_ready();
        if (redirect_en) begin
            m_q.delete();
            m_fpc   = redirect_pc & ~64'd3;
            m_fence = redirect_fence_i;
            if (m_phase == P_FETCH && !hs) begin
                m_phase = P_DISCARD;
                m_hold  = a;
            end else if (m_phase == P_DISCARD && !hs) begin
                m_phase = P_DISCARD;
            end else begin
                m_phase = redirect_fence_i ? P_FENCE : P_FETCH;
            end
        end else begin
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            case (m_phase)
                P_FETCH: if (hs) begin
                    for (int k = s; k < FW; k++) begin
                        e.pc   = a + 64'(4 * k);
                        e.inst = inst_of(e.pc);
                        e.err  = ibus_acc_err;
                        m_q.push_back(e);
                    end
                    m_fpc = a + 64'(4 * FW);
                    if (ibus_acc_err) m_phase = P_HALT;
                end
                P_DISCARD: if (hs) m_phase = m_fence ? P_FENCE : P_FETCH;
                P_FENCE:   m_phase = P_FETCH;
                default:   m_phase = m_phase;
            endcase
        end
    endtask

    // Per-cycle compare of every DUT output against the model
    always @(negedge clk) begin : cmp_p
        logic e_en;
        logic e_valid;
        if (check_en) begin
            e_en    = !rst && (m_phase == P_FETCH || m_phase == P_DISCARD);
            e_valid = (m_q.size() > 0);
            chk("ibus_en", ibus_en, e_en);
            chk("ibus_ready", ibus_ready, !rst && m_ready());
            chk("ibus_fence_i", ibus_fence_i, !rst && m_phase == P_FENCE);
            if (e_en) chk("ibus_addr", ibus_addr, (m_phase == P_DISCARD) ? m_hold : m_align());
            chk("out_valid", out_valid, e_valid);
            chk("out_pc", out_pc, e_valid ? m_q[0].pc : 64'd0);
            chk("out_inst", out_inst, e_valid ? m_q[0].inst : 32'd0);
            chk("out_acc_err", out_acc_err, e_valid ? m_q[0].err : 1'b0);
        end
    end

    task automatic tick();
        if (rec_en && !rst && !redirect_en && out_valid && out_ready) popped.push_back(out_pc);
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic redir(input logic [63:0] pc, input logic f);
        redirect_en      = 1'b1;
        redirect_pc      = pc;
        redirect_fence_i = f;
        tick();
        redirect_en      = 1'b0;
        redirect_fence_i = 1'b0;
    endtask

    // From FETCH: park the pending beat in DISCARD, then let the cache complete it
    task automatic redirect_clean(input logic [63:0] pc);
        ibus_valid = 1'b0;
        redir(pc, 1'b0);
        ibus_valid = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = 64'd0; redirect_fence_i = 1'b0;
        ibus_valid = 1'b0; ibus_acc_err = 1'b0; out_ready = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        tick();
        chk("rst_ibus_en", ibus_en, 1'b0);
        chk("rst_ibus_ready", ibus_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, 64'd0);

        // Basic fetch
        rst = 1'b0; ibus_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("basic_pc0", out_pc, 64'h8000_0000);
        chk("basic_inst0", out_inst, 32'h0010_0093);
        chk("basic_next_addr", ibus_addr, 64'h8000_0008);
        tick();
        chk("basic_pc1", out_pc, 64'h8000_0004);
        chk("basic_inst1", out_inst, 32'h0020_0093);

        // Unaligned redirect: only the upper slot is queued
        redirect_clean(64'h8000_0104);
        chk("unal_addr", ibus_addr, 64'h8000_0100);
        out_ready = 1'b0;
        tick();
        chk("unal_pc", out_pc, 64'h8000_0104);
        chk("unal_inst", out_inst, 32'h0420_0093);
        chk("unal_next_addr", ibus_addr, 64'h8000_0108);
        ibus_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("unal_single", out_valid, 1'b0);

        // Backpressure
        out_ready = 1'b0;
        redirect_clean(64'h8000_1000);
        for (int i = 0; i < 7; i++) tick();
        chk("bp_full_ready", ibus_ready, 1'b0);
        chk("bp_addr_held", ibus_addr, 64'h8000_1020);
        chk("bp_en_held", ibus_en, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("bp_7_ready", ibus_ready, 1'b0);
        tick();
        chk("bp_6_ready", ibus_ready, 1'b1);
        out_ready = 1'b0;
        tick();

        // Stale discard
        out_ready = 1'b1;
        redirect_clean(64'h8000_0010);
        ibus_valid = 1'b0;
        tick();
        redir(64'h8000_2000, 1'b0);
        tick();
        chk("disc_addr_held", ibus_addr, 64'h8000_0010);
        ibus_valid = 1'b1; out_ready = 1'b0;
        tick();
        chk("disc_empty", out_valid, 1'b0);
        chk("disc_new_addr", ibus_addr, 64'h8000_2000);
        tick();
        chk("disc_first_pc", out_pc, 64'h8000_2000);
        chk("disc_first_inst", out_inst, 32'h8010_0093);

        // Access fault
        out_ready = 1'b1;
        redirect_clean(64'h8000_0040);
        ibus_acc_err = 1'b1; out_ready = 1'b0;
        tick();
        ibus_acc_err = 1'b0;
        chk("err_flag0", out_acc_err, 1'b1);
        chk("err_pc0", out_pc, 64'h8000_0040);
        chk("err_halt_en", ibus_en, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("err_flag1", out_acc_err, 1'b1);
        chk("err_pc1", out_pc, 64'h8000_0044);
        tick();
        tick();
        chk("err_drained", out_valid, 1'b0);
        chk("err_still_halt", ibus_en, 1'b0);
        redir(64'h8000_0200, 1'b0);
        chk("err_resume_en", ibus_en, 1'b1);
        chk("err_resume_addr", ibus_addr, 64'h8000_0200);

        // fence_i then long run across pointer wrap
        ibus_valid = 1'b0;
        redir(64'h8000_3000, 1'b1);
        ibus_valid = 1'b1;
        tick();
        chk("fence_pulse", ibus_fence_i, 1'b1);
        chk("fence_en_low", ibus_en, 1'b0);
        tick();
        chk("fence_done", ibus_fence_i, 1'b0);
        chk("fence_fetch_addr", ibus_addr, 64'h8000_3000);
        chk("fence_fetch_en", ibus_en, 1'b1);
        rec_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ibus_valid = ($urandom_range(0, 3) != 0);
            out_ready  = $urandom_range(0, 1) == 1;
            tick();
        end
        ibus_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        rec_en = 1'b0;
        chk("wrap_drained", out_valid, 1'b0);
        chk("wrap_count", popped.size() > 3 * DEPTH, 1'b1);
        for (int i = 0; i < popped.size(); i++) begin
            chk("wrap_contig", popped[i], 64'h8000_3000 + 64'(4 * i));
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
